// File: rtl/prbs_frame_checker.sv
// prbs_frame_checker
//   Receive-side PRBS-31 (x^31 + x^28 + 1) checker for one lane of the 10G MAC
//   user RX stream. It seeds itself from the received data and walks a
//   HUNT -> VERIFY -> LOCKED state machine. It keeps saturating counts of bit
//   errors and checked beats (LOCKED only), and of frames and MAC-flagged bad
//   frames (any state).
//
//   Optional build macro: PRBS_CHK_LEN_CHECK_EN enables the per-frame length
//   check feeding len_err_cnt_o. Without it the port is tied to zero and no
//   length logic is built. The port list is the same in both builds.
//
// Ports
//   rx_user_clk_i    RX user clock
//   rx_user_rst_i    asynchronous active-high reset
//   rx_data_i        beat data, bit 31 is the earliest PRBS bit
//   rx_vldb_i        valid bytes on the last beat (00 = all 4, 1..3 = top k bytes)
//   rx_valid_i       beat qualifier (no backpressure)
//   rx_last_i        final beat of frame
//   rx_user_i        MAC bad-frame flag, sampled with rx_last_i
//   clear_i          synchronous clear of all statistics counters
//   locked_o         checker is in LOCKED
//   err_o            one-cycle pulse per errored beat checked in LOCKED
//   err_cnt_o        saturating bit-error count
//   beat_cnt_o       saturating count of beats checked in LOCKED
//   frame_cnt_o      saturating count of last beats
//   user_err_cnt_o   saturating count of frames flagged bad by the MAC
//   len_err_cnt_o    saturating count of frames whose length != FRAME_BEATS
module prbs_frame_checker #(
   parameter int LOCK_CNT    = 8,
   parameter int UNLOCK_CNT  = 4,
   parameter int FRAME_BEATS = 64,
   parameter int CNT_W       = 32
) (
   input  logic             rx_user_clk_i,
   input  logic             rx_user_rst_i,
   input  logic [31:0]      rx_data_i,
   input  logic [1:0]       rx_vldb_i,
   input  logic             rx_valid_i,
   input  logic             rx_last_i,
   input  logic             rx_user_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] beat_cnt_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] user_err_cnt_o,
   output logic [CNT_W-1:0] len_err_cnt_o
);

   localparam int STAGES = 1;
   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

   if (LOCK_CNT < 1 || UNLOCK_CNT < 1 || FRAME_BEATS < 1 || CNT_W < 6) begin : g_bad_param
      $error("prbs_frame_checker: illegal parameter value");
   end

   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  vldb;
      logic        last;
      logic        user;
   } beat_t;

   // History is the last 31 received bits, newest in bit 0. Producing 32 new
   // bits MSB-first makes the low 31 bits of the result the next history.
   function automatic logic [31:0] prbs_next32(input logic [30:0] st);
      logic [30:0] h;
      logic [31:0] w;
      logic        b;
      h = st;
      w = '0;
      for (int i = 31; i >= 0; i--) begin
         b    = h[30] ^ h[27];
         w[i] = b;
         h    = {h[29:0], b};
      end
      return w;
   endfunction

   // Saturating add. The sum is widened by one bit so a carry out clamps to all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   beat_t            beat;
   state_t           state_q;
   logic [30:0]      lfsr_q;
   logic [31:0]      pred;
   logic [31:0]      cmp_mask;
   logic [31:0]      diff;
   logic             beat_err;
   logic [RUN_W-1:0] run_q;
   logic [BAD_W-1:0] bad_q;
   logic [STAGES:0]  vld_pipe;
   logic [31:0]      diff_q;
   logic [5:0]       pop;
   logic             frame_end;

   assign beat = '{data: rx_data_i, vldb: rx_vldb_i, last: rx_last_i, user: rx_user_i};
   assign pred = prbs_next32(lfsr_q);

   // vldb only trims the compare on the last beat. The dropped low bytes can
   // never count as errors.
   always_comb begin
      cmp_mask = '1;
      if (beat.last) begin
         case (beat.vldb)
            2'b01:   cmp_mask = 32'hFF00_0000;
            2'b10:   cmp_mask = 32'hFFFF_0000;
            2'b11:   cmp_mask = 32'hFFFF_FF00;
            default: cmp_mask = '1;
         endcase
      end
   end

   assign diff      = (beat.data ^ pred) & cmp_mask;
   assign beat_err  = |diff;
   assign frame_end = rx_valid_i & beat.last;

   // Hunt / verify / lock. Every valid beat advances the prediction by a full
   // 32 bits. Once verified, the LFSR only follows its own prediction, so
   // corrupted beats cannot pull it off the sequence.
   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
      if (rx_user_rst_i) begin
         state_q  <= HUNT;
         lfsr_q   <= '0;
         run_q    <= '0;
         bad_q    <= '0;
         locked_o <= 1'b0;
      end else if (rx_valid_i) begin
         case (state_q)
            HUNT: begin
               lfsr_q  <= beat.data[30:0];
               run_q   <= '0;
               state_q <= VERIFY;
            end
            VERIFY: begin
               lfsr_q <= pred[30:0];
               if (beat_err) begin
                  state_q <= HUNT;
               end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                  state_q  <= LOCKED;
                  locked_o <= 1'b1;
                  bad_q    <= '0;
               end else begin
                  run_q <= run_q + RUN_W'(1);
               end
            end
            LOCKED: begin
               lfsr_q <= pred[30:0];
               if (!beat_err) begin
                  bad_q <= '0;
               end else if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                  state_q  <= HUNT;
                  locked_o <= 1'b0;
               end else begin
                  bad_q <= bad_q + BAD_W'(1);
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: the masked difference of beats checked in LOCKED. Other beats
   // enter as zero so they cannot reach the error counters.
   assign vld_pipe[0] = rx_valid_i & (state_q == LOCKED);

   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
      if (rx_user_rst_i) begin
         vld_pipe[STAGES:1] <= '0;
         diff_q             <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         diff_q             <= vld_pipe[0] ? diff : '0;
      end
   end

   assign pop = 6'($countones(diff_q));

   // Stage 2: the error pulse and the popcount accumulation. A clear on the
   // same edge wins and drops the in-flight increment.
   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
      if (rx_user_rst_i) begin
         err_o          <= 1'b0;
         err_cnt_o      <= '0;
         beat_cnt_o     <= '0;
         frame_cnt_o    <= '0;
         user_err_cnt_o <= '0;
      end else begin
         err_o <= vld_pipe[STAGES] & (pop != 6'd0);
         if (clear_i) begin
            err_cnt_o      <= '0;
            beat_cnt_o     <= '0;
            frame_cnt_o    <= '0;
            user_err_cnt_o <= '0;
         end else begin
            if (vld_pipe[STAGES]) begin
               err_cnt_o  <= sat_add(err_cnt_o, pop);
               beat_cnt_o <= sat_add(beat_cnt_o, 6'd1);
            end
            if (frame_end) begin
               frame_cnt_o <= sat_add(frame_cnt_o, 6'd1);
               if (beat.user)
                  user_err_cnt_o <= sat_add(user_err_cnt_o, 6'd1);
            end
         end
      end
   end

`ifdef PRBS_CHK_LEN_CHECK_EN
   // Beats since the previous last, counted in every state. The counter sticks
   // at its top value, which is always above FRAME_BEATS, so very long frames
   // cannot wrap round to a false match.
   localparam int LEN_W = $clog2(FRAME_BEATS + 1) + 1;

   logic [LEN_W-1:0] flen_q;
   logic [LEN_W-1:0] flen_inc;

   assign flen_inc = (&flen_q) ? flen_q : flen_q + LEN_W'(1);

   always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
      if (rx_user_rst_i) begin
         flen_q        <= '0;
         len_err_cnt_o <= '0;
      end else begin
         if (rx_valid_i)
            flen_q <= beat.last ? '0 : flen_inc;
         if (clear_i)
            len_err_cnt_o <= '0;
         else if (frame_end && (flen_inc != LEN_W'(FRAME_BEATS)))
            len_err_cnt_o <= sat_add(len_err_cnt_o, 6'd1);
      end
   end
`else
   assign len_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prbs_frame_checker.sv
module tb_prbs_frame_checker;

   localparam int FB = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rx_data;
   logic [1:0]  rx_vldb;
   logic        rx_valid, rx_last, rx_user, clear;

   logic        locked_f, err_f;
   logic [31:0] err_cnt_f, beat_cnt_f, frame_cnt_f, user_cnt_f, len_cnt_f;
   logic        locked_s, err_s;
   logic [7:0]  err_cnt_s, beat_cnt_s, frame_cnt_s, user_cnt_s, len_cnt_s;

   prbs_frame_checker dut_f (
      .rx_user_clk_i(clk), .rx_user_rst_i(rst), .rx_data_i(rx_data), .rx_vldb_i(rx_vldb),
      .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_user_i(rx_user), .clear_i(clear),
      .locked_o(locked_f), .err_o(err_f), .err_cnt_o(err_cnt_f), .beat_cnt_o(beat_cnt_f),
      .frame_cnt_o(frame_cnt_f), .user_err_cnt_o(user_cnt_f), .len_err_cnt_o(len_cnt_f));

   // Narrow-counter copy on the same stream so saturation is reachable.
   prbs_frame_checker #(.CNT_W(8)) dut_s (
      .rx_user_clk_i(clk), .rx_user_rst_i(rst), .rx_data_i(rx_data), .rx_vldb_i(rx_vldb),
      .rx_valid_i(rx_valid), .rx_last_i(rx_last), .rx_user_i(rx_user), .clear_i(clear),
      .locked_o(locked_s), .err_o(err_s), .err_cnt_o(err_cnt_s), .beat_cnt_o(beat_cnt_s),
      .frame_cnt_o(frame_cnt_s), .user_err_cnt_o(user_cnt_s), .len_err_cnt_o(len_cnt_s));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // err_o scoreboard: one entry per driven cycle, due two edges later.
   typedef struct {int due; logic exp;} sb_t;
   sb_t sbq[$];

   always @(negedge clk) begin
      sb_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         cmp("err_o", {63'd0, err_f}, {63'd0, e.exp});
         cmp("err_o_s", {63'd0, err_s}, {63'd0, e.exp});
      end
   end

   // Reference PRBS-31 stream, s[n] = s[n-31] ^ s[n-28], MSB of each word first.
   logic [30:0] g = 31'h2AF35C19;
   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      logic        nb;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         nb = g[30] ^ g[27];
         w  = {w[30:0], nb};
         g  = {g[29:0], nb};
      end
      return w;
   endfunction

   // Expected counters, unsaturated; clamped at compare time.
   longint e_err = 0, e_beat = 0, e_frame = 0, e_user = 0, e_len = 0;
   longint pend_bits = 0, pend_beat = 0;
   int     flen = 0;

   function automatic longint satc(input longint v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic check_all(input logic lock);
      cmp("locked", {63'd0, locked_f}, {63'd0, lock});
      cmp("locked_s", {63'd0, locked_s}, {63'd0, lock});
      cmp("err_cnt", 64'(err_cnt_f), satc(e_err, 32));
      cmp("beat_cnt", 64'(beat_cnt_f), satc(e_beat, 32));
      cmp("frame_cnt", 64'(frame_cnt_f), satc(e_frame, 32));
      cmp("user_cnt", 64'(user_cnt_f), satc(e_user, 32));
      cmp("len_cnt", 64'(len_cnt_f), satc(e_len, 32));
      cmp("err_cnt_s", 64'(err_cnt_s), satc(e_err, 8));
      cmp("beat_cnt_s", 64'(beat_cnt_s), satc(e_beat, 8));
      cmp("frame_cnt_s", 64'(frame_cnt_s), satc(e_frame, 8));
      cmp("user_cnt_s", 64'(user_cnt_s), satc(e_user, 8));
      cmp("len_cnt_s", 64'(len_cnt_s), satc(e_len, 8));
   endtask

   // One clock of stimulus. chk: beat is expected to be checked in LOCKED;
   // bits: expected bit errors it contributes; exp_lock: locked_o after the edge.
   task automatic step(input logic [31:0] flip, input logic vld, input logic last,
                       input logic [1:0] vldb, input logic user, input logic clr,
                       input logic chk, input int bits, input logic exp_lock);
      if (vld) rx_data = gen_word() ^ flip;
      else     rx_data = $urandom();
      rx_valid = vld; rx_last = last; rx_vldb = vldb; rx_user = user; clear = clr;
      sbq.push_back('{due: cyc + 2, exp: vld && chk && (bits != 0)});
      @(posedge clk); #1;
      if (clr) begin
         e_err = 0; e_beat = 0; e_frame = 0; e_user = 0; e_len = 0;
      end else begin
         e_err  += pend_bits;
         e_beat += pend_beat;
         if (vld && last) begin
            e_frame++;
            if (user) e_user++;
         end
      end
`ifdef PRBS_CHK_LEN_CHECK_EN
      if (vld) begin
         flen++;
         if (last) begin
            if (!clr && flen != FB) e_len++;
            flen = 0;
         end
      end
`endif
      pend_bits = (vld && chk) ? longint'(bits) : 0;
      pend_beat = (vld && chk) ? 1 : 0;
      check_all(exp_lock);
   endtask

   task automatic idle(input logic exp_lock);
      step(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0, exp_lock);
   endtask

   // Async reset in the middle of a cycle; outputs must drop before any edge.
   task automatic do_reset();
      rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0; clear = 1'b0;
      rst = 1'b1;
      e_err = 0; e_beat = 0; e_frame = 0; e_user = 0; e_len = 0;
      pend_bits = 0; pend_beat = 0; flen = 0;
      #2;
      check_all(1'b0);
      cmp("err_o_rst", {63'd0, err_f}, 64'd0);
      rst = 1'b0;
      sbq.push_back('{due: cyc + 2, exp: 1'b0});
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0] flip;
      logic        last;
      logic [1:0]  vldb;
      logic        clr;
      logic        chk;
      int          bits;
      logic        lock;
   } vec_t;
   vec_t tv[$];

   function automatic void add(input logic [31:0] flip, input logic last, input logic [1:0] vldb,
                               input logic clr, input logic chk, input int bits, input logic lock);
      tv.push_back('{flip: flip, last: last, vldb: vldb, clr: clr, chk: chk, bits: bits, lock: lock});
   endfunction

   initial begin
      int nb;

      // Single-bit error in LOCKED
      add(32'h0001_0000, 0, 2'b00, 0, 1, 1, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      // Four fully inverted beats: unlock on the fourth, relock after seed + 8
      for (int k = 0; k < 4; k++) add(32'hFFFF_FFFF, 0, 2'b00, 0, 1, 32, k < 3);
      for (int k = 0; k < 9; k++) add(32'h0, 0, 2'b00, 0, 0, 0, k == 8);
      // Byte-mask boundaries on last beats; vldb ignored on a non-last beat
      add(32'h00FF_FFFF, 1, 2'b01, 0, 1, 0, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      add(32'h0000_0100, 1, 2'b11, 0, 1, 1, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      add(32'h0000_8000, 1, 2'b10, 0, 1, 0, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      add(32'h0000_0001, 1, 2'b00, 0, 1, 1, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      add(32'h0000_0001, 0, 2'b01, 0, 1, 1, 1);
      add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      // Drive the 8-bit copy into saturation and hold it there
      for (int k = 0; k < 5; k++) begin
         add(32'hFFFF_FFFF, 0, 2'b00, 0, 1, 32, 1);
         add(32'h0, 0, 2'b00, 0, 1, 0, 1);
      end
      // Clear on the count-update edge of an errored beat, with a last beat
      add(32'hFFFF_FFFF, 0, 2'b00, 0, 1, 32, 1);
      add(32'h0, 1, 2'b00, 1, 1, 0, 1);
      add(32'h0, 1, 2'b00, 0, 1, 0, 1);

      rst = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
      rx_vldb = 2'b00; rx_data = '0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all(1'b0);
      cmp("err_o_reset", {63'd0, err_f}, 64'd0);
      rst = 1'b0;

      // Clean lock-up: seed + 8 verify beats, checked from beat 10
      for (int i = 1; i <= 100; i++)
         step(32'h0, 1'b1, (i == 64) || (i == 100), 2'b00, 1'b0, 1'b0, i >= 10, 0, i >= 9);

      for (int i = 0; i < tv.size(); i++)
         step(tv[i].flip, 1'b1, tv[i].last, tv[i].vldb, 1'b0, tv[i].clr, tv[i].chk,
              tv[i].bits, tv[i].lock);

      // Gappy traffic: a 63-beat MAC-flagged frame, then a 64-beat clean frame
      nb = 0;
      while (nb < 63) begin
         if ($urandom_range(0, 3) == 0) idle(1'b1);
         else begin
            nb++;
            step(32'h0, 1'b1, nb == 63, 2'b00, nb == 63, 1'b0, 1'b1, 0, 1'b1);
         end
      end
      nb = 0;
      while (nb < FB) begin
         if ($urandom_range(0, 3) == 0) idle(1'b1);
         else begin
            nb++;
            step(32'h0, 1'b1, nb == FB, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b1);
         end
      end

      // Reset mid-frame: the first post-reset beat seeds the checker
      for (int i = 0; i < 5; i++) step(32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      do_reset();
      for (int i = 0; i < 9; i++) step(32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0, i == 8);
      for (int i = 0; i < 3; i++) step(32'h0, 1'b1, i == 2, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      repeat (2) @(negedge clk);
      #1;
      cmp("sb_drained", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prbs_frame_checker.md
Name: prbs_frame_checker

Overview:
- Receive-side PRBS-31 checker for one lane of the 10G MAC user RX stream; consumes the beats produced by the lane's PRBS generator after they cross the link.
- Self-seeds from the received data, runs a hunt/verify/lock state machine, and counts bit errors, beats, frames and MAC-flagged bad frames.
- One instance per lane in link test tops; its per-lane error pulse is OR-reduced into the board debug pin.

Parameters:
- LOCK_CNT, 8, consecutive clean beats in VERIFY required to declare lock
- UNLOCK_CNT, 4, consecutive errored beats in LOCKED that force HUNT
- FRAME_BEATS, 64, expected beats per frame (optional length check only)
- CNT_W, 32, width of every statistics counter

Ports:
- rx_user_clk_i  in  1  RX user clock
- rx_user_rst_i  in  1  reset, asynchronous, active-high
- rx_data_i  in  32  beat data; bit 31 is the earliest PRBS bit
- rx_vldb_i  in  2  valid bytes on last beat: 2'b00 = 4 bytes, 2'b01..2'b11 = 1..3 bytes from bit 31 down; ignored on non-last beats
- rx_valid_i  in  1  beat qualifier; no backpressure
- rx_last_i  in  1  final beat of frame
- rx_user_i  in  1  MAC bad-frame flag, sampled with rx_last_i
- clear_i  in  1  synchronous clear of all counters
- locked_o  out  1  checker in LOCKED
- err_o  out  1  one-cycle pulse per errored beat while LOCKED
- err_cnt_o  out  CNT_W  saturating bit-error count
- beat_cnt_o  out  CNT_W  saturating count of beats checked while LOCKED
- frame_cnt_o  out  CNT_W  saturating count of rx_last_i beats
- user_err_cnt_o  out  CNT_W  saturating count of frames with rx_user_i=1
- len_err_cnt_o  out  CNT_W  saturating count of frames whose length differs from FRAME_BEATS

Behaviour:
- Reset: state HUNT; LFSR 0; all outputs and counters 0.
- Polynomial x^31+x^28+1, s[n]=s[n-31]^s[n-28]. Each valid beat advances the prediction by exactly 32 bits, regardless of vldb. Cycles with rx_valid_i=0 do not advance it.
- Byte mask: non-last beats, or last with vldb=00: all 4 bytes compared. vldb=k (1..3): top k bytes compared, the remaining bytes are never errors.
- FSM:
  - HUNT: first valid beat loads the seed from rx_data_i[30:0] -> VERIFY with clean-run counter 0.
  - VERIFY: valid beat with a masked mismatch -> HUNT, reseeding on the next beat. After LOCK_CNT consecutive clean beats -> LOCKED.
  - LOCKED: clean beat clears the bad-run counter. Errored beat increments it; reaching UNLOCK_CNT -> HUNT. The LFSR keeps free-running from its own prediction and is never reseeded from errored data.
- Pipeline:
  - Stage 1 registers the masked XOR of data and prediction.
  - Stage 2 registers the popcount (0..32) and flags.
  - err_o and the err_cnt_o update appear 2 cycles after the beat.
  - locked_o changes 1 cycle after the deciding beat.
- Error counting: err_cnt_o += popcount and beat_cnt_o += 1, only for beats checked in LOCKED. Errors seen in HUNT and VERIFY are not counted.
- Frame counting: frame_cnt_o and user_err_cnt_o count in every state.
- Saturation: every counter holds at all-ones, no wrap. An addition that would overflow clamps to all-ones.
- clear_i: all counters read 0 next cycle. Clear wins over any coincident increment, and that increment is dropped. FSM and lock state are unaffected.
- Async reset mid-frame: immediate return to HUNT. The first post-reset beat, even mid-frame, is used as the seed.

Optional Feature:
- PRBS_CHK_LEN_CHECK_EN defined: beats since the previous last are counted, inclusive of the last beat, in every state. At rx_last_i, if count != FRAME_BEATS, len_err_cnt_o increments. The per-frame beat count resets on last and on reset.
- Undefined: len_err_cnt_o is tied to 0 and no length logic is built. Port list is identical in both builds.

Test Plan:
- Reset, then 100 clean back-to-back PRBS-31 beats -> locked_o=1 on the cycle after beat 9 (seed + LOCK_CNT=8); err_cnt_o=0; beat_cnt_o counts only beats checked in LOCKED.
- After lock, flip 1 bit of one beat -> single err_o pulse 2 cycles later; err_cnt_o=1; locked_o stays 1.
- After lock, invert all bits of 4 consecutive beats -> err_cnt_o=128; locked_o falls after the 4th; 9 further clean beats -> locked_o=1 again.
- Last beat with vldb=2'b01 and bytes [23:0] corrupted -> no err_o; err_cnt_o unchanged; frame_cnt_o +1.
- Frame ending with rx_user_i=1; random rx_valid_i gaps -> user_err_cnt_o=1; no false errors from gaps; with the macro defined and a 63-beat frame -> len_err_cnt_o=1.
- Preload err_cnt_o near saturation, then apply clear_i on the same cycle as an errored beat's count update -> err_cnt_o reads 0 next cycle, and saturation holds at 32'hFFFFFFFF.
